// File: rtl/popcount_pkg.sv
// Shared constants for the time-multiplexed ones counter.
// State encoding and the per-cycle group size.
package popcount_pkg;

  localparam int GRP = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ones_count3.sv
// Three-input ones counter: y1 is the majority, y0 the parity.
// One instance is shared across every group of the word.
module ones_count3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y1,
  output logic y0
);

  assign y1 = (a & b) | (a & c) | (b & c);
  assign y0 = a ^ b ^ c;

endmodule

// File: rtl/popcount_sequencer.sv
// Multi-cycle popcount: one 3-bit group per cycle through a shared cell.
// Start/done handshake toward the requester; outputs decode from state.
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter  int WIDTH = 12,
  localparam int G     = (WIDTH + GRP - 1) / GRP,
  localparam int SW    = GRP * G,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int GIW   = (G > 1) ? $clog2(G) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  state_e           state_q;
  logic [SW-1:0]    sh_q;
  logic [CW-1:0]    acc_q;
  logic [GIW-1:0]   gi_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    sum_d;
  logic             y1;
  logic             y0;

  ones_count3 u_cell (
    .a  (sh_q[2]),
    .b  (sh_q[1]),
    .c  (sh_q[0]),
    .y1 (y1),
    .y0 (y0)
  );

  // Padding groups are zero, so the 2-bit cell value always fits CW.
  assign sum_d = acc_q + CW'({y1, y0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      gi_q    <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sh_q    <= SW'(data_in);
            acc_q   <= '0;
            gi_q    <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= sum_d;
          sh_q  <= sh_q >> GRP;
          gi_q  <= gi_q + GIW'(1);
          if (gi_q == GIW'(G - 1)) begin
            count_q <= sum_d;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign count = count_q;

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed and random checks of popcount_sequencer at WIDTH 12, 8 and 1.
// Expected counts come from a bit-loop model of the accepted word.
module tb_popcount_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s12, s8, s1;
  logic [11:0] d12;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic        r12, b12, o12;
  logic        r8, b8, o8;
  logic        r1, b1, o1;
  logic [3:0]  c12;
  logic [3:0]  c8;
  logic [0:0]  c1;

  int checks = 0;
  int errors = 0;

  popcount_sequencer #(.WIDTH(12)) u_w12 (
    .clk(clk), .rst_n(rst_n), .start(s12), .data_in(d12),
    .ready(r12), .busy(b12), .done(o12), .count(c12)
  );

  popcount_sequencer #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .data_in(d8),
    .ready(r8), .busy(b8), .done(o8), .count(c8)
  );

  popcount_sequencer #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .data_in(d1),
    .ready(r1), .busy(b1), .done(o1), .count(c1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pop(input int w, input logic [11:0] d);
    int n;
    n = 0;
    for (int i = 0; i < w; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic logic [31:0] rdy(input int w);
    case (w)
      12: return 32'(r12);
      8: return 32'(r8);
      default: return 32'(r1);
    endcase
  endfunction

  function automatic logic [31:0] bsy(input int w);
    case (w)
      12: return 32'(b12);
      8: return 32'(b8);
      default: return 32'(b1);
    endcase
  endfunction

  function automatic logic [31:0] dn(input int w);
    case (w)
      12: return 32'(o12);
      8: return 32'(o8);
      default: return 32'(o1);
    endcase
  endfunction

  function automatic logic [31:0] cnt(input int w);
    case (w)
      12: return 32'(c12);
      8: return 32'(c8);
      default: return 32'(c1);
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [11:0] d);
    case (w)
      12: begin s12 = s; d12 = d; end
      8: begin s8 = s; d8 = d[7:0]; end
      default: begin s1 = s; d1 = d[0]; end
    endcase
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (rdy(w) !== 32'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("idle_timeout", rdy(w), 1);
  endtask

  // One accepted word: latency, hold of old count, result, return to idle.
  task automatic txn(input int w, input logic [11:0] d);
    int g;
    int lat;
    logic [31:0] prev;
    g = (w + 2) / 3;
    lat = 0;
    @(negedge clk);
    chk("ready_before", rdy(w), 1);
    prev = cnt(w);
    drive(w, 1'b1, d);
    @(negedge clk);
    drive(w, 1'b0, 12'($urandom));
    while (dn(w) !== 32'd1 && lat < 4 * g + 8) begin
      chk("busy_run", bsy(w), 1);
      chk("ready_low_run", rdy(w), 0);
      chk("count_hold", cnt(w), prev);
      @(negedge clk);
      lat++;
    end
    chk("done_latency", lat, g);
    chk("count_value", cnt(w), pop(w, d));
    chk("ready_low_done", rdy(w), 0);
    chk("busy_low_done", bsy(w), 0);
    @(negedge clk);
    chk("done_pulse_end", dn(w), 0);
    chk("ready_back", rdy(w), 1);
    chk("count_kept", cnt(w), pop(w, d));
  endtask

  initial begin
    int acc_t[$];
    int dones;
    int lat;
    int cyc;

    drive(12, 1'b0, 12'h000);
    drive(8, 1'b0, 12'h000);
    drive(1, 1'b0, 12'h000);
    #2;
    chk("rst_ready", 32'(r12), 1);
    chk("rst_busy", 32'(b12), 0);
    chk("rst_done", 32'(o12), 0);
    chk("rst_count", 32'(c12), 0);
    chk("rst_count8", 32'(c8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(12, 12'h000);
    txn(12, 12'hFFF);
    txn(12, 12'hA5A);

    // Start held high: accepts only on ready, G+2 cycles apart.
    wait_idle(12);
    dones = 0;
    cyc = 0;
    drive(12, 1'b1, 12'hA5A);
    while (cyc < 14) begin
      if (r12 === 1'b1) acc_t.push_back(cyc);
      if (o12 === 1'b1) begin
        chk("b2b_count", 32'(c12), 6);
        dones++;
      end
      @(negedge clk);
      cyc++;
    end
    drive(12, 1'b0, 12'h000);
    chk("b2b_accepts", acc_t.size(), 3);
    chk("b2b_spacing", acc_t.size() >= 2 ? acc_t[1] - acc_t[0] : -1, 6);
    chk("b2b_dones", dones, 2);
    wait_idle(12);

    // Start held during RUN with new data is ignored.
    drive(12, 1'b1, 12'h001);
    @(negedge clk);
    drive(12, 1'b1, 12'hFFF);
    lat = 0;
    while (o12 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_latency", lat, 4);
    chk("hold_count", 32'(c12), 1);
    drive(12, 1'b0, 12'h000);
    @(negedge clk);
    chk("hold_ready", 32'(r12), 1);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (o12 === 1'b1) dones++;
    end
    chk("hold_no_done", dones, 0);

    // Asynchronous reset in the second RUN cycle.
    wait_idle(12);
    drive(12, 1'b1, 12'hFFF);
    @(negedge clk);
    drive(12, 1'b0, 12'h000);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(b12), 0);
    chk("arst_ready", 32'(r12), 1);
    chk("arst_count", 32'(c12), 0);
    chk("arst_done", 32'(o12), 0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (o12 === 1'b1) dones++;
    end
    chk("arst_no_done", dones, 0);
    rst_n = 1'b1;
    txn(12, 12'h0F0);

    repeat (12) txn(12, 12'($urandom));

    txn(8, 12'h0FF);
    txn(8, 12'h080);
    repeat (6) txn(8, 12'($urandom_range(255, 0)));

    txn(1, 12'h001);
    txn(1, 12'h000);
    txn(1, 12'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_sequencer.md
# popcount_sequencer

Multi-cycle ones counter for a WIDTH-bit word, built around a single 3-input ones-count cell that is time-shared across the word. On `start` the block latches the word, then feeds 3 bits per cycle through the cell, accumulating the 2-bit partial counts. It raises a one-cycle `done` pulse with the total and sits between a requester with a start/done handshake and the shared ones-count cell that it sequences.

## Interface
- WIDTH, 12, word width in bits (≥ 1).
- Derived, not overridable:
  - G = ceil(WIDTH/3) groups.
  - CW = clog2(WIDTH+1) count width.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only while `ready`=1.
- data_in  input  WIDTH  word to count. Sampled only on the accepting edge.
- ready  output  1  block idle; a `start` is accepted.
- busy  output  1  counting in progress.
- done  output  1  one-cycle pulse; `count` is valid.
- count  output  CW  ones count of the last accepted word.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- Registers:
  - shift register `sh` (3·G bits; data_in zero-extended in the MSBs);
  - accumulator `acc` (CW bits);
  - group index `gi` (clog2(G) bits, min 1);
  - output register `count`.
- IDLE:
  - `ready`=1.
  - On `start`=1: `sh` ← zero-extended data_in, `acc` ← 0, `gi` ← 0, go to RUN.
- RUN:
  - `busy`=1, `ready`=0.
  - Each cycle: `acc` ← `acc` + ones3(`sh`[2:0]), `sh` ← `sh` >> 3, `gi` ← `gi`+1.
  - When `gi`==G−1, on the same edge: `count` ← final sum, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, `busy`=0, `ready`=0.
  - Unconditionally return to IDLE.
- ones3(a,b,c) is the 2-bit popcount: bit1 = majority, bit0 = XOR.
- Arithmetic is unsigned. `acc` never overflows, because CW covers WIDTH.
- Padding bits are zero and contribute nothing.
- `start` while RUN or DONE is ignored. It is not queued, and in-flight data is unaffected.
- `data_in` changes after the accepting edge have no effect.
- `count` holds its value until the next DONE entry. It does not change on accept.
- Reset, asynchronous and effective at any time, including mid-RUN:
  - state ← IDLE;
  - `sh`, `acc`, `gi`, `count` ← 0;
  - outputs: `ready`=1, `busy`=0, `done`=0, `count`=0.
- After reset deassertion, the first clock edge may accept a `start`.

## Timing
- Edge E0 accepts the request; RUN occupies edges E1..EG.
- `done` is high in the cycle after EG, i.e. a latency of G+1 edges from accept to the `done` rise.
- `ready` returns high one cycle after `done`.
- Minimum spacing between accepted starts is G+2 cycles.
- With G=1 there is exactly one RUN cycle.
- All outputs are registered or decoded from state only, with no combinational path from inputs.
- `ready` = (state==IDLE); `busy` = (state==RUN); `done` = (state==DONE).

## Structure
- Shared package `popcount_pkg` holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the group size constant (3).
- Sub-module `ones_count3`:
  - inputs a, b, c; outputs y1, y0;
  - behavioural 3-input ones counter, instantiated once as the shared datapath cell.
- Top holds the FSM, the shift register, the accumulator and the output register.

## Test plan
- WIDTH=12:
  - reset, then start with data_in=12'h000 → `done` pulses 5 cycles after the accept edge with `count`=0;
  - `ready` low for exactly 5 cycles.
- WIDTH=12:
  - data_in=12'hFFF → `count`=12;
  - data_in=12'hA5A → `count`=6;
  - a back-to-back start asserted continuously is accepted only when `ready`=1, so accepts are 6 cycles apart.
- WIDTH=12:
  - accept data_in=12'h001, then hold `start`=1 with data_in=12'hFFF during RUN → `count`=1;
  - no second `done` until after `ready` returns.
- WIDTH=12:
  - assert rst_n=0 asynchronously mid-edge during the 2nd RUN cycle of 12'hFFF;
  - required: immediately `busy`=0, `ready`=1, `count`=0, and no `done`;
  - a subsequent start with 12'h0F0 → `count`=4.
- WIDTH=8 (G=3, padding):
  - data_in=8'hFF → `count`=8, `done` 4 cycles after accept;
  - data_in=8'h80 → `count`=1.
- WIDTH=1 (G=1):
  - data_in=1 → `count`=1, `done` 2 cycles after accept.
